wb_rect_fill: RTL and testbench

- Wishbone rectangle-fill engine that sits directly upstream of the VGA framebuffer.
- The CPU programs a rectangle and an RGB565 colour through a small Wishbone slave port.
- The engine then drives a Wishbone master that writes packed pixel words into the framebuffer's write port.
- Frees the CPU from per-pixel stores when clearing the screen or drawing filled boxes.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_span_walker.sv | 40 ++++
 rtl/wb_rect_fill.sv | 201 ++++++++++++++++++++
 tb/tb_wb_rect_fill.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and types for the rectangle-fill engine and its span walker.
package fb_pkg;

  localparam int FB_W_DEF = 320;
  localparam int FB_H_DEF = 240;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_POS   = 2'd1;
  localparam logic [1:0] REG_SIZE  = 2'd2;
  localparam logic [1:0] REG_COLOR = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_BEAT,
    S_ROW,
    S_DONE
  } state_t;

endpackage

// File: rtl/fb_span_walker.sv
// Walks one row from the start column to the clipped end column, choosing
// full-word or half-word beats so that every pixel is written exactly once.
module fb_span_walker (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [15:0] x0_i,
  input  logic [15:0] x1_i,
  output logic [3:0]  sel_o,
  output logic        last_o
);

  logic [15:0] cx_q, cx_d;
  logic        full;
  logic [16:0] cx_next;

  // A full word needs an even column with its odd neighbour still inside the span.
  always_comb begin
    full    = ~cx_q[0] && (cx_q < x1_i);
    sel_o   = cx_q[0] ? 4'b0011 : (full ? 4'b1111 : 4'b1100);
    cx_next = {1'b0, cx_q} + (full ? 17'd2 : 17'd1);
    last_o  = cx_next > {1'b0, x1_i};
    cx_d    = cx_q;
    if (load_i) begin
      cx_d = x0_i;
    end else if (adv_i) begin
      cx_d = cx_next[15:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cx_q <= 16'd0;
    end else begin
      cx_q <= cx_d;
    end
  end

endmodule

// File: rtl/wb_rect_fill.sv
// Wishbone rectangle-fill engine: CPU-programmed rectangle and RGB565 colour,
// written into the framebuffer as packed two-pixel words over a Wishbone master.
module wb_rect_fill
  import fb_pkg::*;
#(
  parameter int FB_W   = FB_W_DEF,
  parameter int FB_H   = FB_H_DEF,
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_s_cyc,
  input  logic              i_s_stb,
  input  logic              i_s_we,
  input  logic [1:0]        i_s_addr,
  input  logic [31:0]       i_s_data,
  output logic              o_s_ack,
  output logic [31:0]       o_s_data,
  output logic              o_m_cyc,
  output logic              o_m_stb,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [31:0]       o_m_data,
  output logic [3:0]        o_m_sel,
  input  logic              i_m_ack,
  output logic              o_irq
);

  localparam logic [ADDR_W-1:0] HALF_W = ADDR_W'(FB_W / 2);
  localparam logic [15:0]       FB_W16 = 16'(FB_W);
  localparam logic [15:0]       FB_H16 = 16'(FB_H);

  state_t              state_q, state_d;
  logic                s_ack_q;
  logic [31:0]         s_data_q;
  logic [15:0]         x_q, y_q, w_q, h_q;
  logic [RGB_W-1:0]    color_q;
  logic                busy_q, busy_d, done_q, done_d;
  logic [15:0]         x1_q, x1_d, y1_q, y1_d, cy_q, cy_d, mcand_q, mcand_d;
  logic [ADDR_W-1:0]   rowbase_q, rowbase_d, mult_q, mult_d, addr_q, addr_d, xword;
  logic                span_load, span_adv, span_last;
  logic [3:0]          span_sel;
  logic                s_req, s_wr, s_rd, start, clr, empty;
  logic [16:0]         xsum, ysum, xclip, yclip;

  assign s_req = i_s_cyc & i_s_stb & ~s_ack_q;
  assign s_wr  = s_req & i_s_we;
  assign s_rd  = s_req & ~i_s_we;
  assign start = s_wr && (i_s_addr == REG_CTRL) && i_s_data[0] && !busy_q;
  assign clr   = s_wr && (i_s_addr == REG_CTRL) && i_s_data[1];
  assign empty = (w_q == 16'd0) || (h_q == 16'd0) || (x_q >= FB_W16) || (y_q >= FB_H16);
  assign xsum  = {1'b0, x_q} + {1'b0, w_q};
  assign ysum  = {1'b0, y_q} + {1'b0, h_q};
  assign xclip = (xsum > 17'(FB_W)) ? 17'(FB_W) : xsum;
  assign yclip = (ysum > 17'(FB_H)) ? 17'(FB_H) : ysum;
  assign xword = ADDR_W'(x_q[15:1]);

  // Register file; geometry and colour are frozen while a fill is running.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s_ack_q  <= 1'b0;
      s_data_q <= 32'd0;
      x_q      <= 16'd0;
      y_q      <= 16'd0;
      w_q      <= 16'd0;
      h_q      <= 16'd0;
      color_q  <= '0;
    end else begin
      s_ack_q <= s_req;
      if (s_rd) begin
        case (i_s_addr)
          REG_CTRL:  s_data_q <= {30'd0, done_q, busy_q};
          REG_POS:   s_data_q <= {y_q, x_q};
          REG_SIZE:  s_data_q <= {h_q, w_q};
          default:   s_data_q <= {16'd0, color_q};
        endcase
      end
      if (s_wr && !busy_q) begin
        case (i_s_addr)
          REG_POS:   begin x_q <= i_s_data[15:0]; y_q <= i_s_data[31:16]; end
          REG_SIZE:  begin w_q <= i_s_data[15:0]; h_q <= i_s_data[31:16]; end
          REG_COLOR: color_q <= i_s_data[RGB_W-1:0];
          default:   ;
        endcase
      end
    end
  end

  // SETUP forms Y*(FB_W/2) by shift-and-add over the bits of Y.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = clr ? 1'b0 : done_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    cy_d      = cy_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    rowbase_d = rowbase_q;
    addr_d    = addr_q;
    span_load = 1'b0;
    span_adv  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d    = 1'b0;
          busy_d    = 1'b1;
          x1_d      = 16'(xclip - 17'd1);
          y1_d      = 16'(yclip - 17'd1);
          cy_d      = y_q;
          mcand_d   = y_q;
          mult_d    = HALF_W;
          rowbase_d = '0;
          span_load = 1'b1;
          state_d   = empty ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: begin
        if (mcand_q == 16'd0) begin
          addr_d  = rowbase_q + xword;
          state_d = S_BEAT;
        end else begin
          if (mcand_q[0]) rowbase_d = rowbase_q + mult_q;
          mult_d  = mult_q << 1;
          mcand_d = mcand_q >> 1;
        end
      end
      S_BEAT: begin
        if (i_m_ack) begin
          span_adv = 1'b1;
          addr_d   = addr_q + 1'b1;
          if (span_last) state_d = S_ROW;
        end
      end
      S_ROW: begin
        cy_d      = cy_q + 16'd1;
        rowbase_d = rowbase_q + HALF_W;
        if (cy_q >= y1_q) begin
          state_d = S_DONE;
        end else begin
          span_load = 1'b1;
          addr_d    = rowbase_q + HALF_W + xword;
          state_d   = S_BEAT;
        end
      end
      default: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x1_q      <= 16'd0;
      y1_q      <= 16'd0;
      cy_q      <= 16'd0;
      mcand_q   <= 16'd0;
      mult_q    <= '0;
      rowbase_q <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      cy_q      <= cy_d;
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      rowbase_q <= rowbase_d;
      addr_q    <= addr_d;
    end
  end

  fb_span_walker u_span (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .load_i (span_load),
    .adv_i  (span_adv),
    .x0_i   (x_q),
    .x1_i   (x1_q),
    .sel_o  (span_sel),
    .last_o (span_last)
  );

  assign o_s_ack  = s_ack_q;
  assign o_s_data = s_data_q;
  assign o_m_cyc  = (state_q == S_BEAT);
  assign o_m_stb  = (state_q == S_BEAT);
  assign o_m_we   = (state_q == S_BEAT);
  assign o_m_addr = addr_q;
  assign o_m_data = {color_q, color_q};
  assign o_m_sel  = (state_q == S_BEAT) ? span_sel : 4'b0000;
  assign o_irq    = done_q;

endmodule

// File: tb/tb_wb_rect_fill.sv
// Self-checking bench for wb_rect_fill: directed and randomized fills compared
// against a pixel-by-pixel reference model of the framebuffer writes.
module tb_wb_rect_fill;

  localparam int FBW = 320;
  localparam int FBH = 240;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_s_cyc, i_s_stb, i_s_we;
  logic [1:0]  i_s_addr;
  logic [31:0] i_s_data;
  logic        o_s_ack;
  logic [31:0] o_s_data;
  logic        o_m_cyc, o_m_stb, o_m_we;
  logic [15:0] o_m_addr;
  logic [31:0] o_m_data;
  logic [3:0]  o_m_sel;
  logic        i_m_ack;
  logic        o_irq;

  logic ackGate = 1'b1;
  logic ackForce = 1'b0;
  logic ackRand = 1'b1;
  logic randomAck = 1'b0;

  logic [51:0] obs[$];
  logic [51:0] expQ[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  wb_rect_fill #(.FB_W(FBW), .FB_H(FBH), .ADDR_W(16)) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_s_cyc  (i_s_cyc),
    .i_s_stb  (i_s_stb),
    .i_s_we   (i_s_we),
    .i_s_addr (i_s_addr),
    .i_s_data (i_s_data),
    .o_s_ack  (o_s_ack),
    .o_s_data (o_s_data),
    .o_m_cyc  (o_m_cyc),
    .o_m_stb  (o_m_stb),
    .o_m_we   (o_m_we),
    .o_m_addr (o_m_addr),
    .o_m_data (o_m_data),
    .o_m_sel  (o_m_sel),
    .i_m_ack  (i_m_ack),
    .o_irq    (o_irq)
  );

  assign i_m_ack = ackForce | (o_m_stb & ackGate & ackRand);

  always @(posedge i_clk) begin
    #1;
    ackRand = randomAck ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  always @(negedge i_clk) begin
    if (o_m_cyc && o_m_stb && i_m_ack) obs.push_back({o_m_addr, o_m_sel, o_m_data});
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wbWrite(input logic [1:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(posedge i_clk); #1;
    i_s_cyc = 1'b1; i_s_stb = 1'b1; i_s_we = 1'b1; i_s_addr = a; i_s_data = d;
    do begin @(negedge i_clk); n++; end while (!o_s_ack && n < 8);
    if (!o_s_ack) checkOutput("slaveWriteAck", 64'(o_s_ack), 64'd1);
    @(posedge i_clk); #1;
    i_s_cyc = 1'b0; i_s_stb = 1'b0; i_s_we = 1'b0;
  endtask

  task automatic wbRead(input logic [1:0] a, output logic [31:0] d);
    int n;
    n = 0;
    @(posedge i_clk); #1;
    i_s_cyc = 1'b1; i_s_stb = 1'b1; i_s_we = 1'b0; i_s_addr = a;
    do begin @(negedge i_clk); n++; end while (!o_s_ack && n < 8);
    if (!o_s_ack) checkOutput("slaveReadAck", 64'(o_s_ack), 64'd1);
    d = o_s_data;
    @(posedge i_clk); #1;
    i_s_cyc = 1'b0; i_s_stb = 1'b0;
  endtask

  // Reference: visit every pixel of the clipped rectangle in raster order and
  // merge horizontally adjacent pixels that share a framebuffer word.
  function automatic void buildExpected(input int x, input int y, input int w, input int h,
                                        input logic [15:0] color);
    int xe, ye, pix;
    logic [15:0] word;
    logic [3:0] s;
    expQ.delete();
    if (w == 0 || h == 0 || x >= FBW || y >= FBH) return;
    xe = ((x + w) < FBW ? (x + w) : FBW) - 1;
    ye = ((y + h) < FBH ? (y + h) : FBH) - 1;
    for (int yy = y; yy <= ye; yy++) begin
      for (int xx = x; xx <= xe; xx++) begin
        pix  = yy * FBW + xx;
        word = 16'(pix / 2);
        s    = (pix % 2 == 0) ? 4'b1100 : 4'b0011;
        if (expQ.size() > 0 && expQ[expQ.size()-1][51:36] == word)
          expQ[expQ.size()-1] = expQ[expQ.size()-1] | {16'd0, s, 32'd0};
        else
          expQ.push_back({word, s, color, color});
      end
    end
  endfunction

  task automatic applyStimulus(input int x, input int y, input int w, input int h,
                               input logic [15:0] color);
    wbWrite(2'd1, {16'(y), 16'(x)});
    wbWrite(2'd2, {16'(h), 16'(w)});
    wbWrite(2'd3, {16'd0, color});
    buildExpected(x, y, w, h, color);
    obs.delete();
    wbWrite(2'd0, 32'd1);
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (!o_irq && n < budget) begin @(negedge i_clk); n++; end
    checkOutput("doneReached", 64'(o_irq), 64'd1);
  endtask

  task automatic compareWrites(input string tag);
    int m;
    checkOutput({tag, "Count"}, 64'(obs.size()), 64'(expQ.size()));
    m = (obs.size() < expQ.size()) ? obs.size() : expQ.size();
    for (int i = 0; i < m; i++) checkOutput(tag, 64'(obs[i]), 64'(expQ[i]));
  endtask

  task automatic waitStb(input string tag);
    int n;
    n = 0;
    while (!o_m_stb && n < 40) begin @(negedge i_clk); n++; end
    checkOutput(tag, 64'(o_m_stb), 64'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [51:0] snap;
    int rx, ry, rw, rh;

    i_reset_n = 1'b0;
    i_s_cyc = 1'b0; i_s_stb = 1'b0; i_s_we = 1'b0; i_s_addr = 2'd0; i_s_data = 32'd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("resetCtl", 64'({o_m_cyc, o_m_stb, o_m_we, o_s_ack, o_irq, o_m_sel, o_m_addr}), 64'd0);
    checkOutput("resetData", {o_m_data, o_s_data}, 64'd0);
    i_reset_n = 1'b1;
    wbRead(2'd0, rd);
    checkOutput("resetCtrlReg", 64'(rd), 64'd0);

    $display("[TB] aligned fill");
    applyStimulus(0, 0, 4, 2, 16'hF800);
    waitDone(200);
    compareWrites("aligned");
    wbRead(2'd0, rd);
    checkOutput("alignedCtrl", 64'(rd), 64'h2);
    checkOutput("alignedIrq", 64'(o_irq), 64'd1);
    wbWrite(2'd0, 32'd2);
    checkOutput("doneCleared", 64'(o_irq), 64'd0);
    wbRead(2'd3, rd);
    checkOutput("colorReadback", 64'(rd), 64'h0000F800);

    $display("[TB] odd edges");
    applyStimulus(1, 1, 2, 1, 16'h001F);
    waitDone(200);
    compareWrites("oddEdges");

    $display("[TB] clipping");
    applyStimulus(318, 239, 10, 5, 16'(($urandom)));
    waitDone(200);
    compareWrites("clipping");

    $display("[TB] empty rectangles");
    applyStimulus(5, 5, 0, 3, 16'h1234);
    checkOutput("emptyWDone", 64'(o_irq), 64'd1);
    repeat (5) @(negedge i_clk);
    checkOutput("emptyWWrites", 64'(obs.size()), 64'd0);
    applyStimulus(320, 5, 4, 3, 16'h1234);
    checkOutput("emptyXDone", 64'(o_irq), 64'd1);
    repeat (5) @(negedge i_clk);
    checkOutput("emptyXWrites", 64'(obs.size()), 64'd0);

    $display("[TB] back-pressure");
    ackGate = 1'b0;
    applyStimulus(0, 2, 8, 1, 16'hA5A5);
    waitStb("bpStbRise");
    @(posedge i_clk); #1 ackGate = 1'b1;
    @(posedge i_clk); #1 ackGate = 1'b0;
    @(negedge i_clk);
    snap = {o_m_addr, o_m_sel, o_m_data};
    wbWrite(2'd0, 32'd1);
    wbWrite(2'd1, 32'h0033_0044);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      checkOutput("bpStable", 64'({o_m_cyc, o_m_stb, o_m_addr, o_m_sel, o_m_data}), 64'({2'b11, snap}));
    end
    ackGate = 1'b1;
    waitDone(200);
    compareWrites("backPressure");
    wbRead(2'd1, rd);
    checkOutput("bpPosKept", 64'(rd), 64'h0002_0000);

    $display("[TB] randomized fills");
    for (int i = 0; i < 10; i++) begin
      randomAck = (i % 2 == 1);
      ackForce  = (i % 4 == 2);
      rx = $urandom_range(0, 330);
      ry = $urandom_range(0, 245);
      rw = $urandom_range(0, 24);
      rh = $urandom_range(0, 4);
      applyStimulus(rx, ry, rw, rh, 16'($urandom));
      waitDone(2000);
      compareWrites("random");
    end
    randomAck = 1'b0;
    ackForce  = 1'b0;
    @(posedge i_clk); #2;

    $display("[TB] reset mid-fill");
    ackGate = 1'b0;
    applyStimulus(0, 10, 16, 2, 16'h07E0);
    waitStb("rstStbRise");
    @(posedge i_clk); #1 ackGate = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk); #1 ackGate = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b0;
    #1;
    checkOutput("rstDropsBus", 64'({o_m_cyc, o_m_stb}), 64'd0);
    checkOutput("rstBeatsBefore", 64'(obs.size()), 64'd2);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    ackGate = 1'b1;
    repeat (30) @(negedge i_clk);
    checkOutput("rstNoMoreWrites", 64'(obs.size()), 64'd2);
    for (int a = 0; a < 4; a++) begin
      wbRead(2'(a), rd);
      checkOutput("rstRegZero", 64'(rd), 64'd0);
    end
    checkOutput("rstIrq", 64'(o_irq), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
